// File: rtl/fcsr_port_arbiter_if.sv
// Signal bundle around fcsr_port_arbiter: instruction request/response, FPU flag
// retire and the CSR register-file port. Names are from the arbiter's point of view.
interface fcsr_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_ins_valid;
    logic            o_ins_ready;
    logic [11:0]     i_ins_addr;
    logic [1:0]      i_ins_op;
    logic            i_ins_we;
    logic [XLEN-1:0] i_ins_wdata;
    logic [XLEN-1:0] o_ins_rdata;
    logic            o_ins_done;
    logic            i_fpu_valid;
    logic [4:0]      i_fpu_flags;
    logic [11:0]     o_csr_addr;
    logic [1:0]      o_csr_op;
    logic            o_csr_write;
    logic [XLEN-1:0] o_csr_wdata;
    logic [XLEN-1:0] i_csr_rdata;
    logic            o_busy;

    modport slave (
        input  i_ins_valid, i_ins_addr, i_ins_op, i_ins_we, i_ins_wdata,
        input  i_fpu_valid, i_fpu_flags, i_csr_rdata,
        output o_ins_ready, o_ins_rdata, o_ins_done,
        output o_csr_addr, o_csr_op, o_csr_write, o_csr_wdata, o_busy
    );

    modport master (
        output i_ins_valid, i_ins_addr, i_ins_op, i_ins_we, i_ins_wdata,
        output i_fpu_valid, i_fpu_flags, i_csr_rdata,
        input  o_ins_ready, o_ins_rdata, o_ins_done,
        input  o_csr_addr, o_csr_op, o_csr_write, o_csr_wdata, o_busy
    );
endinterface

// File: rtl/fcsr_port_arbiter.sv
// Shares the single CSR register-file port between CSR instructions and the
// sticky FPU exception-flag accumulator, which is drained into fflags with CSRRS.
module fcsr_port_arbiter #(
    parameter int XLEN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fcsr_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]  OP_RW       = 2'b00;
    localparam logic [1:0]  OP_RS       = 2'b01;
    localparam logic [11:0] ADDR_FFLAGS = 12'h001;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_grant;
    logic            w_drain;
    logic [4:0]      w_fpu_in;
    logic [4:0]      w_pend_eff;
    logic [4:0]      r_pend;
    logic            r_credit;
    logic [11:0]     w_csr_addr_nxt;
    logic [1:0]      w_csr_op_nxt;
    logic            w_csr_write_nxt;
    logic [XLEN-1:0] w_csr_wdata_nxt;
    logic [11:0]     r_csr_addr;
    logic [1:0]      r_csr_op;
    logic            r_csr_write;
    logic [XLEN-1:0] r_csr_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_done;

    // Flags retiring this cycle count as pending for the IDLE decision, so a
    // drain snapshot includes them; flags arriving while in DRAIN go to the new pend.
    assign w_fpu_in   = bus.i_fpu_valid ? bus.i_fpu_flags : 5'd0;
    assign w_pend_eff = r_pend | w_fpu_in;

    // Next-state decode; the drain credit lets a waiting instruction pass after one drain.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_drain     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_ins_valid && (r_credit || (w_pend_eff == 5'd0))) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end else if (w_pend_eff != 5'd0) begin
                    w_drain     = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: w_state_nxt = ST_IDLE;
            ST_EXEC:  w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // CSR port contents for the state being entered; zero whenever the port is not owned.
    always_comb begin
        w_csr_addr_nxt  = 12'h000;
        w_csr_op_nxt    = OP_RW;
        w_csr_write_nxt = 1'b0;
        w_csr_wdata_nxt = {XLEN{1'b0}};
        if (w_drain) begin
            w_csr_addr_nxt  = ADDR_FFLAGS;
            w_csr_op_nxt    = OP_RS;
            w_csr_write_nxt = 1'b1;
            w_csr_wdata_nxt = {{(XLEN-5){1'b0}}, w_pend_eff};
        end else if (w_grant) begin
            w_csr_addr_nxt  = bus.i_ins_addr;
            w_csr_op_nxt    = bus.i_ins_op;
            w_csr_write_nxt = bus.i_ins_we;
            w_csr_wdata_nxt = bus.i_ins_wdata;
        end else begin
            w_csr_addr_nxt  = 12'h000;
            w_csr_op_nxt    = OP_RW;
            w_csr_write_nxt = 1'b0;
            w_csr_wdata_nxt = {XLEN{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending-flag accumulator and drain credit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend   <= 5'd0;
            r_credit <= 1'b0;
        end else begin
            r_pend <= w_drain ? 5'd0 : (r_pend | w_fpu_in);
            if (w_drain) begin
                r_credit <= 1'b1;
            end else if (w_grant) begin
                r_credit <= 1'b0;
            end
        end
    end

    // Registered CSR port; r_csr_wdata doubles as the drain snapshot, so reset discards it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csr_addr  <= 12'h000;
            r_csr_op    <= OP_RW;
            r_csr_write <= 1'b0;
            r_csr_wdata <= {XLEN{1'b0}};
        end else begin
            r_csr_addr  <= w_csr_addr_nxt;
            r_csr_op    <= w_csr_op_nxt;
            r_csr_write <= w_csr_write_nxt;
            r_csr_wdata <= w_csr_wdata_nxt;
        end
    end

    // Old CSR value captured at the end of EXEC and the RESP completion pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= {XLEN{1'b0}};
            r_done  <= 1'b0;
        end else begin
            if (r_state == ST_EXEC) begin
                r_rdata <= bus.i_csr_rdata;
            end
            r_done <= (w_state_nxt == ST_RESP);
        end
    end

    assign bus.o_ins_ready = w_grant & i_rst_n;
    assign bus.o_ins_rdata = r_rdata;
    assign bus.o_ins_done  = r_done;
    assign bus.o_csr_addr  = r_csr_addr;
    assign bus.o_csr_op    = r_csr_op;
    assign bus.o_csr_write = r_csr_write;
    assign bus.o_csr_wdata = r_csr_wdata;
    assign bus.o_busy      = (r_state != ST_IDLE) || (r_pend != 5'd0);
endmodule

// File: tb/tb_fcsr_port_arbiter.sv
// Directed bench for fcsr_port_arbiter with a small fflags/frm/fcsr register-file
// model on the CSR port and queue-based scoreboards for port writes and responses.
module tb_fcsr_port_arbiter;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [11:0]     addr;
        logic [1:0]      op;
        logic [XLEN-1:0] wdata;
    } port_t;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   errors = 0;
    int   checks = 0;

    port_t           exp_port_q[$];
    logic [XLEN-1:0] exp_rdata_q[$];

    logic [7:0] m_fcsr;
    logic [7:0] m_next;
    logic [7:0] m_tmp;

    always #5 i_clk = ~i_clk;

    fcsr_port_arbiter_if #(.XLEN(XLEN)) bus ();

    fcsr_port_arbiter #(.XLEN(XLEN)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    function automatic logic [7:0] csr_rmw(input logic [7:0] old, input logic [7:0] wd,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return wd;
            2'b01:   return old | wd;
            2'b10:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    // Register-file model: fflags (0x001), frm (0x002), fcsr (0x003) views of one byte.
    always_comb begin
        m_next = m_fcsr;
        m_tmp  = 8'h00;
        bus.i_csr_rdata = '0;
        case (bus.o_csr_addr)
            12'h001: begin
                bus.i_csr_rdata = {27'd0, m_fcsr[4:0]};
                m_tmp  = csr_rmw({3'd0, m_fcsr[4:0]}, {3'd0, bus.o_csr_wdata[4:0]}, bus.o_csr_op);
                m_next = {m_fcsr[7:5], m_tmp[4:0]};
            end
            12'h002: begin
                bus.i_csr_rdata = {29'd0, m_fcsr[7:5]};
                m_tmp  = csr_rmw({5'd0, m_fcsr[7:5]}, {5'd0, bus.o_csr_wdata[2:0]}, bus.o_csr_op);
                m_next = {m_tmp[2:0], m_fcsr[4:0]};
            end
            12'h003: begin
                bus.i_csr_rdata = {24'd0, m_fcsr};
                m_next = csr_rmw(m_fcsr, bus.o_csr_wdata[7:0], bus.o_csr_op);
            end
            default: m_next = m_fcsr;
        endcase
    end

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)             m_fcsr <= 8'h00;
        else if (bus.o_csr_write) m_fcsr <= m_next;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampled mid-cycle.
    always @(negedge i_clk) begin
        port_t           ep;
        logic [XLEN-1:0] er;
        if (i_rst_n) begin
            if (bus.o_csr_write) begin
                check("write_expected", 64'(exp_port_q.size() != 0), 64'd1);
                if (exp_port_q.size() != 0) begin
                    ep = exp_port_q.pop_front();
                    check("port_addr",  64'(bus.o_csr_addr),  64'(ep.addr));
                    check("port_op",    64'(bus.o_csr_op),    64'(ep.op));
                    check("port_wdata", 64'(bus.o_csr_wdata), 64'(ep.wdata));
                end
            end
            if (bus.o_ins_done) begin
                check("done_expected", 64'(exp_rdata_q.size() != 0), 64'd1);
                if (exp_rdata_q.size() != 0) begin
                    er = exp_rdata_q.pop_front();
                    check("resp_rdata", 64'(bus.o_ins_rdata), 64'(er));
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_ins(input logic v, input logic [11:0] a, input logic [1:0] op,
                             input logic we, input logic [XLEN-1:0] wd);
        bus.i_ins_valid = v;
        bus.i_ins_addr  = a;
        bus.i_ins_op    = op;
        bus.i_ins_we    = we;
        bus.i_ins_wdata = wd;
    endtask

    task automatic drive_fpu(input logic v, input logic [4:0] f);
        bus.i_fpu_valid = v;
        bus.i_fpu_flags = f;
    endtask

    task automatic push_port(input logic [11:0] a, input logic [1:0] op, input logic [XLEN-1:0] wd);
        port_t p;
        p.addr  = a;
        p.op    = op;
        p.wdata = wd;
        exp_port_q.push_back(p);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        drive_ins(1'b0, 12'h000, 2'b00, 1'b0, '0);
        drive_fpu(1'b0, 5'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!bus.o_ins_done && n < max) begin
            tick();
            n++;
        end
        check(tag, 64'(bus.o_ins_done), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        drive_ins(1'b1, 12'h003, 2'b00, 1'b1, 32'hE5);
        drive_fpu(1'b1, 5'h1F);
        #3;
        check("rst_ready", 64'(bus.o_ins_ready), 64'd0);
        check("rst_done",  64'(bus.o_ins_done),  64'd0);
        check("rst_write", 64'(bus.o_csr_write), 64'd0);
        check("rst_addr",  64'(bus.o_csr_addr),  64'd0);
        check("rst_rdata", 64'(bus.o_ins_rdata), 64'd0);
        check("rst_busy",  64'(bus.o_busy),      64'd0);
        do_reset();

        // RW fcsr with 0xE5, then a back-to-back read of fcsr
        drive_ins(1'b1, 12'h003, 2'b00, 1'b1, 32'hE5);
        push_port(12'h003, 2'b00, 32'hE5);
        exp_rdata_q.push_back(32'h0);
        #1 check("a_ready_c0", 64'(bus.o_ins_ready), 64'd1);
        tick();
        bus.i_ins_valid = 1'b0;
        #1;
        check("a_write_c1", 64'(bus.o_csr_write), 64'd1);
        check("a_ready_c1", 64'(bus.o_ins_ready), 64'd0);
        check("a_busy_c1",  64'(bus.o_busy),      64'd1);
        tick();
        drive_ins(1'b1, 12'h003, 2'b01, 1'b0, '0);
        exp_rdata_q.push_back(32'hE5);
        #1;
        check("a_done_c2",    64'(bus.o_ins_done),  64'd1);
        check("a_ready_resp", 64'(bus.o_ins_ready), 64'd0);
        tick();
        check("a_ready_c3", 64'(bus.o_ins_ready), 64'd1);
        tick();
        bus.i_ins_valid = 1'b0;
        tick();
        check("a_done_c5", 64'(bus.o_ins_done), 64'd1);
        tick();
        check("a_done_low",   64'(bus.o_ins_done),  64'd0);
        check("a_rdata_hold", 64'(bus.o_ins_rdata), 64'hE5);
        check("a_busy_idle",  64'(bus.o_busy),      64'd0);

        // Flags 0x01 then 0x10: two drains, fflags reads 0x11
        do_reset();
        drive_fpu(1'b1, 5'h01);
        push_port(12'h001, 2'b01, 32'h01);
        tick();
        drive_fpu(1'b1, 5'h10);
        push_port(12'h001, 2'b01, 32'h10);
        tick();
        drive_fpu(1'b0, 5'd0);
        check("b_busy_pend", 64'(bus.o_busy), 64'd1);
        tick();
        tick();
        tick();
        check("b_busy_clear", 64'(bus.o_busy), 64'd0);
        drive_ins(1'b1, 12'h001, 2'b01, 1'b0, '0);
        exp_rdata_q.push_back(32'h11);
        tick();
        bus.i_ins_valid = 1'b0;
        wait_done("b_done", 6);
        tick();

        // Flags 0x04 with a same-cycle fflags read: drain first, read sees 0x04
        do_reset();
        drive_fpu(1'b1, 5'h04);
        drive_ins(1'b1, 12'h001, 2'b01, 1'b0, '0);
        push_port(12'h001, 2'b01, 32'h04);
        exp_rdata_q.push_back(32'h04);
        #1 check("c_ready_c0", 64'(bus.o_ins_ready), 64'd0);
        tick();
        drive_fpu(1'b0, 5'd0);
        #1 check("c_ready_drain", 64'(bus.o_ins_ready), 64'd0);
        tick();
        check("c_ready_c2", 64'(bus.o_ins_ready), 64'd1);
        tick();
        bus.i_ins_valid = 1'b0;
        tick();
        check("c_done_c4", 64'(bus.o_ins_done), 64'd1);
        tick();

        // Continuous 0x02 flags with a waiting read: one drain, then grant
        do_reset();
        drive_fpu(1'b1, 5'h02);
        drive_ins(1'b1, 12'h001, 2'b01, 1'b0, '0);
        push_port(12'h001, 2'b01, 32'h02);
        exp_rdata_q.push_back(32'h02);
        #1 check("d_ready_c0", 64'(bus.o_ins_ready), 64'd0);
        tick();
        check("d_ready_c1", 64'(bus.o_ins_ready), 64'd0);
        tick();
        check("d_ready_c2", 64'(bus.o_ins_ready), 64'd1);
        tick();
        bus.i_ins_valid = 1'b0;
        tick();
        check("d_done_by_4", 64'(bus.o_ins_done), 64'd1);
        drive_fpu(1'b0, 5'd0);
        push_port(12'h001, 2'b01, 32'h02);
        repeat (4) tick();
        check("d_busy_end", 64'(bus.o_busy), 64'd0);

        // Flags 0x08 on the first DRAIN cycle feed a second drain
        do_reset();
        drive_fpu(1'b1, 5'h01);
        push_port(12'h001, 2'b01, 32'h01);
        tick();
        drive_fpu(1'b1, 5'h08);
        push_port(12'h001, 2'b01, 32'h08);
        tick();
        drive_fpu(1'b0, 5'd0);
        repeat (3) tick();
        check("e_busy_end", 64'(bus.o_busy), 64'd0);

        // Reset during EXEC with flags pending: no done, outputs clear at once
        do_reset();
        drive_fpu(1'b1, 5'h01);
        drive_ins(1'b1, 12'h001, 2'b00, 1'b1, 32'h1F);
        push_port(12'h001, 2'b01, 32'h01);
        tick();
        drive_fpu(1'b1, 5'h08);
        tick();
        drive_fpu(1'b0, 5'd0);
        check("f_ready_grant", 64'(bus.o_ins_ready), 64'd1);
        tick();
        bus.i_ins_valid = 1'b0;
        check("f_exec_write", 64'(bus.o_csr_write), 64'd1);
        i_rst_n = 1'b0;
        #1;
        check("f_rst_write", 64'(bus.o_csr_write), 64'd0);
        check("f_rst_addr",  64'(bus.o_csr_addr),  64'd0);
        check("f_rst_wdata", 64'(bus.o_csr_wdata), 64'd0);
        check("f_rst_done",  64'(bus.o_ins_done),  64'd0);
        check("f_rst_busy",  64'(bus.o_busy),      64'd0);
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("f_no_done", 64'(bus.o_ins_done), 64'd0);
            check("f_no_busy", 64'(bus.o_busy),     64'd0);
        end

        check("port_q_empty",  64'(exp_port_q.size()),  64'd0);
        check("rdata_q_empty", 64'(exp_rdata_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
